shift_tx_ctrl: RTL and testbench

//  Controller that sequences a WIDTH-bit shift register as a parallel-to-serial

---
 rtl/shift_tx_ctrl_if.sv | 7 +
 rtl/shift_tx_ctrl.sv | 71 +++++++
 tb/tb_shift_tx_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_tx_ctrl_if.sv
// shift_tx_ctrl_if: word handshake plus serial output bundle between producer, controller and sink
interface shift_tx_ctrl_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid, din_ready, hold, sout, shift_en, frame, done, busy;
  modport master (output din, din_valid, hold, input din_ready, sout, shift_en, frame, done, busy);
  modport slave (input din, din_valid, hold, output din_ready, sout, shift_en, frame, done, busy);
endinterface

// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: parallel-to-serial frame sequencer with hold stall and inter-frame gap
module shift_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  shift_tx_ctrl_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_nx;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic done_q, done_d;
  assign shreg_nx = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.din_valid) begin
        shreg_d = bus.din;
        bit_cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (!bus.hold) begin
        shreg_d = shreg_nx;
        bit_cnt_d = bit_cnt_q == BLAST ? bit_cnt_q : bit_cnt_q + 1'b1;
        if (bit_cnt_q == BLAST) begin
          done_d = 1'b1;
          gap_cnt_d = '0;
          state_d = GAP_CYCLES == 0 ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q == GLAST ? gap_cnt_q : gap_cnt_q + 1'b1;
        state_d = gap_cnt_q == GLAST ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q <= done_d;
    end
  end
  assign bus.din_ready = state_q == IDLE && !rst;
  assign bus.frame = state_q == SHIFT;
  assign bus.shift_en = state_q == SHIFT && !bus.hold;
  assign bus.sout = state_q == SHIFT && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign bus.done = done_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_shift_tx_ctrl.sv
// tb_shift_tx_ctrl: directed per-cycle vectors against a default instance and an LSB-first, no-gap instance
module tb_shift_tx_ctrl;
  logic clk, rst, din_valid, hold, sel;
  logic [7:0] din;
  int checks, failures;
  shift_tx_ctrl_if #(.WIDTH(8)) bus_a ();
  shift_tx_ctrl_if #(.WIDTH(8)) bus_b ();
  assign bus_a.din = din;
  assign bus_a.din_valid = din_valid;
  assign bus_a.hold = hold;
  assign bus_b.din = din;
  assign bus_b.din_valid = din_valid;
  assign bus_b.hold = hold;
  shift_tx_ctrl u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  shift_tx_ctrl #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_seq(input string tag, input int n, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [15:0] rs, input logic [15:0] vld, input logic [15:0] hld,
                         input logic [15:0] es, input logic [15:0] ef, input logic [15:0] ee,
                         input logic [15:0] ed, input logic [15:0] er, input logic [15:0] eb);
    for (int c = 0; c < n; c++) begin
      rst = rs[c];
      din = c == 0 ? w0 : w1;
      din_valid = vld[c];
      hold = hld[c];
      @(negedge clk);
      check($sformatf("%s c%0d sout", tag, c), sel ? bus_b.sout : bus_a.sout, es[c]);
      check($sformatf("%s c%0d frame", tag, c), sel ? bus_b.frame : bus_a.frame, ef[c]);
      check($sformatf("%s c%0d shift_en", tag, c), sel ? bus_b.shift_en : bus_a.shift_en, ee[c]);
      check($sformatf("%s c%0d done", tag, c), sel ? bus_b.done : bus_a.done, ed[c]);
      check($sformatf("%s c%0d din_ready", tag, c), sel ? bus_b.din_ready : bus_a.din_ready, er[c]);
      check($sformatf("%s c%0d busy", tag, c), sel ? bus_b.busy : bus_a.busy, eb[c]);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    din_valid = 1'b0;
    hold = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    sel = 1'b0;
    rst = 1'b1;
    din = 8'hFF;
    din_valid = 1'b1;
    hold = 1'b0;
    @(posedge clk);
    #1;
    run_seq("reset", 5, 8'hFF, 8'hFF, 16'h0007, 16'h0007, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0018, 16'h0000);
    run_seq("a5", 12, 8'hA5, 8'h00, 16'h0000, 16'h0001, 16'h0000,
            16'h014A, 16'h01FE, 16'h01FE, 16'h0200, 16'h0801, 16'h07FE);
    run_seq("hold", 15, 8'hA5, 8'h00, 16'h0000, 16'h0001, 16'h0038,
            16'h0A7A, 16'h0FFE, 16'h0FC6, 16'h1000, 16'h4001, 16'h3FFE);
    run_seq("busy_valid", 16, 8'hA5, 8'h3C, 16'h0000, 16'h0FFF, 16'h0000,
            16'hC14A, 16'hF1FE, 16'hF1FE, 16'h0200, 16'h0801, 16'hF7FE);
    idle(10);
    run_seq("abort", 11, 8'hA5, 8'h00, 16'h0010, 16'h0001, 16'h0000,
            16'h000A, 16'h001E, 16'h001E, 16'h0000, 16'h07E1, 16'h001E);
    sel = 1'b1;
    run_seq("lsb_nogap", 11, 8'h01, 8'h00, 16'h0000, 16'h0001, 16'h0000,
            16'h0002, 16'h01FE, 16'h01FE, 16'h0200, 16'h0601, 16'h01FE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
